// File: rtl/score_engine_if.sv
// Landing-result / score bus between the landing detector, score_engine and the display.
// Also supplies the default building colour codes when parameter.v is not in the build.
`ifndef RED
`define RED    2'd0
`endif
`ifndef YELLOW
`define YELLOW 2'd1
`endif
`ifndef GREEN
`define GREEN  2'd2
`endif
`ifndef BLUE
`define BLUE   2'd3
`endif

interface score_engine_if #(
    parameter int SCORE_W   = 12,
    parameter int COMBO_MAX = 4
);
    localparam int CW = $clog2(COMBO_MAX + 1);

    logic               start;
    logic               c_En;
    logic               on_second;
    logic               middle;
    logic               fell;
    logic [1:0]         color;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] last_add;
    logic               add_valid;
    logic [CW-1:0]      combo;
    logic               saturated;
    logic               game_over;
    logic [SCORE_W-1:0] hi_score;

    modport master (
        output start, c_En, on_second, middle, fell, color,
        input  score, last_add, add_valid, combo, saturated, game_over, hi_score
    );

    modport slave (
        input  start, c_En, on_second, middle, fell, color,
        output score, last_add, add_valid, combo, saturated, game_over, hi_score
    );
endinterface

// File: rtl/score_engine.sv
// Game score accumulator: colour-weighted jumps, centre-hit combo bonus, saturating score.
// Optional best-score register enabled by defining SCORE_HISCORE_EN.
module score_engine #(
    parameter int SCORE_W   = 12,
    parameter int COMBO_MAX = 4,
    parameter int W_RED     = 20,
    parameter int W_YELLOW  = 10,
    parameter int W_GREEN   = 5,
    parameter int W_BLUE    = 1
) (
    input logic           clk,
    input logic           rst,
    score_engine_if.slave bus
);
    localparam int CW = $clog2(COMBO_MAX + 1);
    localparam logic [SCORE_W-1:0] WR = SCORE_W'(W_RED);
    localparam logic [SCORE_W-1:0] WY = SCORE_W'(W_YELLOW);
    localparam logic [SCORE_W-1:0] WG = SCORE_W'(W_GREEN);
    localparam logic [SCORE_W-1:0] WB = SCORE_W'(W_BLUE);
    localparam logic [CW-1:0]      CMAX = CW'(COMBO_MAX);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t             state_q;
    logic [SCORE_W-1:0] score_q, last_add_q;
    logic [CW-1:0]      combo_q;
    logic               add_valid_q, sat_q;

    logic [CW-1:0]      combo_d;
    logic [SCORE_W-1:0] add_d, score_d;
    logic               clamp_d;

    function automatic logic [SCORE_W-1:0] base_pts(input logic [1:0] c);
        case (c)
            `RED:    return WR;
            `YELLOW: return WY;
            `GREEN:  return WG;
            default: return WB;
        endcase
    endfunction

    // Returns {clamp_flag, value}; the sum is formed one bit wider to catch the carry.
    function automatic logic [SCORE_W:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[SCORE_W]) return {1'b1, {SCORE_W{1'b1}}};
        return s;
    endfunction

    always_comb begin
        combo_d = '0;
        if (bus.middle)
            combo_d = (combo_q >= CMAX) ? CMAX : combo_q + CW'(1);
        add_d              = base_pts(bus.color) + (SCORE_W'(combo_d) << 1);
        {clamp_d, score_d} = sat_add(score_q, add_d);
    end

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] hi_q;
    always_ff @(posedge clk) begin
        if (!rst)
            hi_q <= '0;
        else if (state_q == PLAY && !bus.start && bus.c_En && bus.fell && score_q > hi_q)
            hi_q <= score_q;
    end
    assign bus.hi_score = hi_q;
`else
    assign bus.hi_score = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            score_q     <= '0;
            last_add_q  <= '0;
            combo_q     <= '0;
            add_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            add_valid_q <= 1'b0;
            if (bus.start) begin
                // start wins over any landing result in the same cycle
                state_q    <= PLAY;
                score_q    <= '0;
                last_add_q <= '0;
                combo_q    <= '0;
                sat_q      <= 1'b0;
            end else if (state_q == PLAY && bus.c_En) begin
                if (bus.fell) begin
                    state_q <= OVER;
                    combo_q <= '0;
                end else if (bus.on_second) begin
                    combo_q     <= combo_d;
                    last_add_q  <= add_d;
                    score_q     <= score_d;
                    sat_q       <= sat_q | clamp_d;
                    add_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.score     = score_q;
    assign bus.last_add  = last_add_q;
    assign bus.add_valid = add_valid_q;
    assign bus.combo     = combo_q;
    assign bus.saturated = sat_q;
    assign bus.game_over = (state_q == OVER);
endmodule
